// File: rtl/dmem_pkg.sv
// Shared state type, funct3 codes and store-side helpers for the MEM-stage data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte enables for the addressed lane(s); loads use the same lanes as stores of equal size.
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] a);
    logic [3:0] be;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << a;
      F3_H, F3_HU: be = 4'b0011 << a;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_rep(input logic [2:0] funct3, input logic [31:0] wdata);
    logic [31:0] rep;
    case (funct3)
      F3_B, F3_BU: rep = {4{wdata[7:0]}};
      F3_H, F3_HU: rep = {2{wdata[15:0]}};
      default:     rep = wdata;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a bus read word and sign- or zero-extends it.
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  a,
  output logic [31:0] ldata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*a +: 8];
    half_sel = a[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    ldata = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ldata = {24'b0, byte_sel};
      F3_H:    ldata = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ldata = {16'b0, half_sel};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: sequences one load/store onto a req/gnt/rvalid bus and stalls the pipeline.
// Optional abort-on-timeout is compiled in with DMEM_TIMEOUT_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TCW     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        memren_i,
  input  logic        memwen_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic [31:0] ldata_o,
  output logic        err_o
);

  dmem_state_t state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ldata_q, ldata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic        err_q, err_d;

  logic        is_access, f3_legal, misaligned, accept, reject;
  logic [31:0] ldata_aligned;

`ifdef DMEM_TIMEOUT_EN
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           tmo_hit;
  assign tmo_hit = (tmo_q == TCW'(TIMEOUT - 1));
`else
  logic [TCW-1:0] unused_cfg;
  assign unused_cfg = TCW'(TIMEOUT);
`endif

  // Request decode: both enables set, or a funct3 outside the legal set, is rejected.
  always_comb begin
    f3_legal = 1'b0;
    if (memren_i && !memwen_i)
      f3_legal = funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    else if (memwen_i && !memren_i)
      f3_legal = funct3_i inside {F3_B, F3_H, F3_W};
    case (funct3_i[1:0])
      2'b01:   misaligned = addr_i[0];
      2'b10:   misaligned = (addr_i[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign is_access = valid_i & (memren_i | memwen_i);
  assign accept    = is_access & f3_legal & ~misaligned;
  assign reject    = is_access & ~accept;

  load_align u_load_align (
    .rdata  (bus_rdata_i),
    .funct3 (f3_q),
    .a      (addr_q[1:0]),
    .ldata  (ldata_aligned)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    we_d    = we_q;
    err_d   = 1'b0;
    stall_o = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          state_d = REQ;
          addr_d  = addr_i;
          we_d    = memwen_i;
          be_d    = be_gen(funct3_i, addr_i[1:0]);
          wdata_d = wdata_rep(funct3_i, wdata_i);
          f3_d    = funct3_i;
`ifdef DMEM_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else if (reject) begin
          err_d = 1'b1;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (bus_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        if (bus_rvalid_i) begin
          state_d = DONE;
          if (!we_q) ldata_d = ldata_aligned;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef DMEM_TIMEOUT_EN
    // A response arriving in the final WAIT cycle still completes normally.
    if (state_q == REQ || state_q == WAIT) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_hit && !(state_q == WAIT && bus_rvalid_i)) begin
        state_d = DONE;
        err_d   = 1'b1;
        if (!we_q) ldata_d = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      err_q   <= err_d;
`ifdef DMEM_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus_req_o   = (state_q == REQ);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = {addr_q[31:2], 2'b00};
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;
  assign ldata_o     = ldata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized accesses against a behavioural model.
module tb_dmem_ctrl;

`ifdef DMEM_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, memren_i, memwen_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        stall_o;
  logic [31:0] ldata_o;
  logic        err_o;

  int total = 0;
  int passed = 0;
  int txn = 0;
  logic [31:0] ldata_m;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT(TMO), .TCW(8)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .memren_i(memren_i), .memwen_i(memwen_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .stall_o(stall_o), .ldata_o(ldata_o), .err_o(err_o)
  );

  // ---------------- behavioural reference model ----------------
  function automatic bit m_legal(input bit ren, input bit wen, input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    if (ren == wen) return 1'b0;
    if (ren && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (wen && f3 > 3'd2) return 1'b0;
    sz = 1 << f3[1:0];
    return (int'(addr[1:0]) % sz) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = 1 << f3[1:0];
    return 4'(((1 << sz) - 1) << addr[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz;
    sz = 1 << f3[1:0];
    if (sz == 1) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_ldata(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] v;
    int sz;
    sz = 1 << f3[1:0];
    v = rdata >> (8 * addr[1:0]);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
    end
    return v;
  endfunction

  // ---------------- bus-side driver (observes, does not judge) ----------------
  task automatic run_access(
    input bit v, input bit ren, input bit wen, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
    input int gd, input int rvd, input bit gap,
    output int stall_cnt, output int req_cnt,
    output logic [31:0] a_s, output logic [3:0] be_s, output logic we_s, output logic [31:0] wd_s,
    output bit stable, output logic [31:0] ld_s, output logic err_mid, output logic err_end,
    output logic err_after, output logic err_after2, output logic busy_after);
    int req_idx, wait_idx;
    bit granted, responded, done;
    logic [31:0] r;
    req_idx = 0; wait_idx = 0; granted = 0; responded = 0; done = 0;
    stall_cnt = 0; req_cnt = 0; stable = 1;
    a_s = '0; be_s = '0; we_s = 1'b0; wd_s = '0; ld_s = '0;
    err_mid = 1'b0; err_end = 1'b0; err_after = 1'b0; err_after2 = 1'b0; busy_after = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        valid_i = v; memren_i = ren; memwen_i = wen; funct3_i = f3; addr_i = addr; wdata_i = wd;
      end
      r = $urandom;
      bus_rdata_i = r; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
      if (bus_req_o) begin
        req_cnt++;
        if (req_idx == 0) begin
          a_s = bus_addr_o; be_s = bus_be_o; we_s = bus_we_o; wd_s = bus_wdata_o;
        end else if ({bus_addr_o, bus_be_o, bus_we_o, bus_wdata_o} !== {a_s, be_s, we_s, wd_s}) begin
          stable = 0;
        end
        bus_gnt_i = (req_idx == gd);
        bus_rvalid_i = ($urandom_range(0, 1) == 1);
        if (bus_gnt_i) granted = 1;
        req_idx++;
      end else if (granted && !responded) begin
        bus_gnt_i = ($urandom_range(0, 1) == 1);
        if (wait_idx == rvd) begin
          bus_rvalid_i = 1'b1; bus_rdata_i = rd; responded = 1;
        end
        wait_idx++;
      end else begin
        bus_gnt_i = ($urandom_range(0, 1) == 1);
        bus_rvalid_i = ($urandom_range(0, 1) == 1);
      end
      #1;
      if (stall_o) stall_cnt++;
      if (err_o) err_mid = 1'b1;
      if (!stall_o) begin
        done = 1; ld_s = ldata_o; err_end = err_o;
      end
    end
    total++;
    if (!done) $display("FAIL access_bound: stall_o still high after 300 cycles, required release");
    else passed++;
    if (gap) begin
      @(negedge clk);
      valid_i = 1'b0; memren_i = 1'b0; memwen_i = 1'b0;
      bus_gnt_i = ($urandom_range(0, 1) == 1);
      bus_rvalid_i = ($urandom_range(0, 1) == 1);
      #1;
      err_after = err_o; busy_after = bus_req_o | stall_o;
      @(negedge clk);
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
      #1;
      err_after2 = err_o;
    end
    $display("txn %0d: v=%0b r=%0b w=%0b f3=%0d addr=%h gd=%0d rvd=%0d stall=%0d req=%0d ldata=%h err=%0b",
             txn, v, ren, wen, f3, addr, gd, rvd, stall_cnt, req_cnt, ld_s, err_after);
    txn++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    valid_i = 0; memren_i = 0; memwen_i = 0; funct3_i = '0; addr_i = '0; wdata_i = '0;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus_req_o !== 1'b0) $display("FAIL reset_req: got %b want 0", bus_req_o); else passed++;
    total++; if (bus_we_o !== 1'b0) $display("FAIL reset_we: got %b want 0", bus_we_o); else passed++;
    total++; if (bus_addr_o !== 32'h0) $display("FAIL reset_addr: got %h want 0", bus_addr_o); else passed++;
    total++; if (bus_be_o !== 4'h0) $display("FAIL reset_be: got %b want 0", bus_be_o); else passed++;
    total++; if (bus_wdata_o !== 32'h0) $display("FAIL reset_wdata: got %h want 0", bus_wdata_o); else passed++;
    total++; if (ldata_o !== 32'h0) $display("FAIL reset_ldata: got %h want 0", ldata_o); else passed++;
    total++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else passed++;
    total++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_o); else passed++;
    @(negedge clk);
    rst = 1'b1;
    ldata_m = '0;
  endtask

  task automatic test_loads();
    int sc, rc; logic [31:0] a, wds, ld; logic [3:0] be; logic we, em, ee, ea, ea2, ba; bit st;
    run_access(1, 1, 0, 3'b100, 32'h1003, 32'h0, 32'h80AA55CC, 0, 0, 1, sc, rc, a, be, we, wds, st, ld, em, ee, ea, ea2, ba);
    total++; if (sc !== 3) $display("FAIL lbu_stall: got %0d want 3", sc); else passed++;
    total++; if (ld !== 32'h00000080) $display("FAIL lbu_ldata: got %h want 00000080", ld); else passed++;
    total++; if (be !== 4'b1000) $display("FAIL lbu_be: got %b want 1000", be); else passed++;
    total++; if (a !== 32'h1000) $display("FAIL lbu_addr: got %h want 00001000", a); else passed++;
    total++; if (we !== 1'b0) $display("FAIL lbu_we: got %b want 0", we); else passed++;
    run_access(1, 1, 0, 3'b000, 32'h1003, 32'h0, 32'h80AA55CC, 0, 0, 1, sc, rc, a, be, we, wds, st, ld, em, ee, ea, ea2, ba);
    total++; if (ld !== 32'hFFFFFF80) $display("FAIL lb_ldata: got %h want ffffff80", ld); else passed++;
    run_access(1, 1, 0, 3'b001, 32'h1002, 32'h0, 32'h80011234, 0, 0, 1, sc, rc, a, be, we, wds, st, ld, em, ee, ea, ea2, ba);
    total++; if (ld !== 32'hFFFF8001) $display("FAIL lh_ldata: got %h want ffff8001", ld); else passed++;
    total++; if (be !== 4'b1100) $display("FAIL lh_be: got %b want 1100", be); else passed++;
    total++; if (ldata_o !== 32'hFFFF8001) $display("FAIL lh_hold: got %h want ffff8001", ldata_o); else passed++;
    ldata_m = 32'hFFFF8001;
  endtask

  task automatic test_store();
    int sc, rc; logic [31:0] a, wds, ld; logic [3:0] be; logic we, em, ee, ea, ea2, ba; bit st;
    run_access(1, 0, 1, 3'b000, 32'h2001, 32'h000000AB, 32'h0, 0, 0, 1, sc, rc, a, be, we, wds, st, ld, em, ee, ea, ea2, ba);
    total++; if (we !== 1'b1) $display("FAIL sb_we: got %b want 1", we); else passed++;
    total++; if (a !== 32'h2000) $display("FAIL sb_addr: got %h want 00002000", a); else passed++;
    total++; if (be !== 4'b0010) $display("FAIL sb_be: got %b want 0010", be); else passed++;
    total++; if (wds !== 32'hABABABAB) $display("FAIL sb_wdata: got %h want abababab", wds); else passed++;
    total++; if (ld !== 32'hFFFF8001) $display("FAIL sb_ldata_kept: got %h want ffff8001", ld); else passed++;
    total++; if (sc !== 3) $display("FAIL sb_stall: got %0d want 3", sc); else passed++;
  endtask

  task automatic test_stall_delay();
    int sc, rc; logic [31:0] a, wds, ld, rd; logic [3:0] be; logic we, em, ee, ea, ea2, ba; bit st;
    rd = $urandom;
    run_access(1, 1, 0, 3'b010, 32'h00005004, 32'h0, rd, 4, 1, 1, sc, rc, a, be, we, wds, st, ld, em, ee, ea, ea2, ba);
    total++; if (sc !== 8) $display("FAIL lw_delay_stall: got %0d want 8", sc); else passed++;
    total++; if (rc !== 5) $display("FAIL lw_delay_req_cycles: got %0d want 5", rc); else passed++;
    total++; if (st !== 1'b1) $display("FAIL lw_delay_stable: got %b want 1", st); else passed++;
    total++; if (ld !== rd) $display("FAIL lw_delay_ldata: got %h want %h", ld, rd); else passed++;
    total++; if (be !== 4'b1111) $display("FAIL lw_delay_be: got %b want 1111", be); else passed++;
    ldata_m = rd;
  endtask

  task automatic test_errors();
    bit rens[5] = '{1, 1, 1, 0, 0};
    bit wens[5] = '{0, 0, 1, 1, 1};
    logic [2:0] f3s[5] = '{3'b010, 3'b011, 3'b000, 3'b001, 3'b100};
    logic [31:0] addrs[5] = '{32'h3002, 32'h3000, 32'h3000, 32'h3001, 32'h3000};
    int sc, rc; logic [31:0] a, wds, ld; logic [3:0] be; logic we, em, ee, ea, ea2, ba; bit st;
    for (int i = 0; i < 5; i++) begin
      run_access(1, rens[i], wens[i], f3s[i], addrs[i], 32'h12345678, 32'h0, 0, 0, 1,
                 sc, rc, a, be, we, wds, st, ld, em, ee, ea, ea2, ba);
      total++; if (rc !== 0) $display("FAIL err%0d_req: got %0d req cycles want 0", i, rc); else passed++;
      total++; if (sc !== 0) $display("FAIL err%0d_stall: got %0d want 0", i, sc); else passed++;
      total++; if (ea !== 1'b1) $display("FAIL err%0d_pulse: got %b want 1", i, ea); else passed++;
      total++; if (ea2 !== 1'b0) $display("FAIL err%0d_pulse_end: got %b want 0", i, ea2); else passed++;
      total++; if (ldata_o !== ldata_m) $display("FAIL err%0d_ldata: got %h want %h", i, ldata_o, ldata_m); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    valid_i = 1; memren_i = 1; memwen_i = 0; funct3_i = 3'b010; addr_i = 32'h4000;
    bus_gnt_i = 0; bus_rvalid_i = 0;
    @(negedge clk);
    bus_gnt_i = 1;
    @(negedge clk);
    bus_gnt_i = 0;
    #1;
    total++; if (stall_o !== 1'b1 || bus_req_o !== 1'b0) $display("FAIL rstmid_in_wait: stall=%b req=%b want 1/0", stall_o, bus_req_o); else passed++;
    #2;
    rst = 1'b0; valid_i = 0; memren_i = 0;
    #1;
    total++; if (bus_req_o !== 1'b0) $display("FAIL rstmid_req: got %b want 0", bus_req_o); else passed++;
    total++; if (stall_o !== 1'b0) $display("FAIL rstmid_stall: got %b want 0", stall_o); else passed++;
    total++; if (ldata_o !== 32'h0) $display("FAIL rstmid_ldata: got %h want 0", ldata_o); else passed++;
    total++; if (bus_addr_o !== 32'h0 || bus_be_o !== 4'h0) $display("FAIL rstmid_addr_be: got %h/%b want 0/0", bus_addr_o, bus_be_o); else passed++;
    @(negedge clk);
    rst = 1'b1; bus_rvalid_i = 1; bus_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    bus_rvalid_i = 0;
    #1;
    total++; if (stall_o !== 1'b0 || bus_req_o !== 1'b0) $display("FAIL late_rvalid_idle: stall=%b req=%b want 0/0", stall_o, bus_req_o); else passed++;
    total++; if (ldata_o !== 32'h0) $display("FAIL late_rvalid_ldata: got %h want 0", ldata_o); else passed++;
    total++; if (err_o !== 1'b0) $display("FAIL late_rvalid_err: got %b want 0", err_o); else passed++;
    ldata_m = '0;
  endtask

  task automatic test_back_to_back();
    int sc, rc; logic [31:0] a, wds, ld, rd, ad, r32; logic [3:0] be; logic we, em, ee, ea, ea2, ba; bit st;
    logic [2:0] f3s[4] = '{3'b000, 3'b101, 3'b010, 3'b100};
    for (int i = 0; i < 4; i++) begin
      r32 = $urandom;
      ad = {r32[31:2], 2'b00};
      if (f3s[i] == 3'b000) ad[1:0] = 2'b11;
      if (f3s[i] == 3'b101) ad[1:0] = 2'b10;
      rd = $urandom;
      run_access(1, 1, 0, f3s[i], ad, 32'h0, rd, i % 2, 0, (i == 3), sc, rc, a, be, we, wds, st, ld, em, ee, ea, ea2, ba);
      ldata_m = m_ldata(f3s[i], ad, rd);
      total++; if (ld !== ldata_m) $display("FAIL b2b%0d_ldata: got %h want %h", i, ld, ldata_m); else passed++;
      total++; if (sc !== 3 + (i % 2)) $display("FAIL b2b%0d_stall: got %0d want %0d", i, sc, 3 + (i % 2)); else passed++;
    end
  endtask

  task automatic test_random();
    int sc, rc, gd, rvd, kind, exp_stall; logic [31:0] a, wds, ld, rd, ad, wd, r32; logic [3:0] be;
    logic we, em, ee, ea, ea2, ba; bit st, v, ren, wen, acc, lg; logic [2:0] f3;
    for (int i = 0; i < 60; i++) begin
      v = ($urandom_range(0, 5) != 0);
      kind = $urandom_range(0, 7);
      ren = (kind == 1) || (kind >= 2 && kind <= 4);
      wen = (kind == 1) || (kind >= 5);
      f3 = 3'($urandom_range(0, 7));
      r32 = $urandom;
      ad = {r32[31:2], 2'b00};
      if ($urandom_range(0, 2) == 0) ad[1:0] = 2'($urandom_range(0, 3));
      wd = $urandom; rd = $urandom;
      gd = $urandom_range(0, 2); rvd = $urandom_range(0, 2);
      run_access(v, ren, wen, f3, ad, wd, rd, gd, rvd, 1, sc, rc, a, be, we, wds, st, ld, em, ee, ea, ea2, ba);
      acc = v && (ren || wen);
      lg = acc && m_legal(ren, wen, f3, ad);
      exp_stall = lg ? 3 + gd + rvd : 0;
      if (lg && ren) ldata_m = m_ldata(f3, ad, rd);
      total++; if (sc !== exp_stall) $display("FAIL rnd%0d_stall: got %0d want %0d", i, sc, exp_stall); else passed++;
      total++; if (ea !== (acc && !lg)) $display("FAIL rnd%0d_err: got %b want %b", i, ea, acc && !lg); else passed++;
      total++; if (ld !== ldata_m) $display("FAIL rnd%0d_ldata: got %h want %h", i, ld, ldata_m); else passed++;
      total++; if (ba !== 1'b0 || ea2 !== 1'b0 || em !== 1'b0) $display("FAIL rnd%0d_quiet: busy=%b err2=%b errmid=%b want 0", i, ba, ea2, em); else passed++;
      if (lg) begin
        total++; if (a !== {ad[31:2], 2'b00}) $display("FAIL rnd%0d_addr: got %h want %h", i, a, {ad[31:2], 2'b00}); else passed++;
        total++; if (be !== m_be(f3, ad)) $display("FAIL rnd%0d_be: got %b want %b", i, be, m_be(f3, ad)); else passed++;
        total++; if (we !== wen || st !== 1'b1) $display("FAIL rnd%0d_we_stable: got %b/%b want %b/1", i, we, st, wen); else passed++;
        if (wen) begin
          total++; if (wds !== m_wdata(f3, wd)) $display("FAIL rnd%0d_wdata: got %h want %h", i, wds, m_wdata(f3, wd)); else passed++;
        end
      end else begin
        total++; if (rc !== 0) $display("FAIL rnd%0d_noreq: got %0d req cycles want 0", i, rc); else passed++;
      end
    end
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    int sc, rc; logic [31:0] a, wds, ld; logic [3:0] be; logic we, em, ee, ea, ea2, ba; bit st;
    run_access(1, 1, 0, 3'b010, 32'h6000, 32'h0, 32'h55AA55AA, 1000, 0, 1, sc, rc, a, be, we, wds, st, ld, em, ee, ea, ea2, ba);
    total++; if (rc !== TMO) $display("FAIL tmo_req_cycles: got %0d want %0d", rc, TMO); else passed++;
    total++; if (sc !== TMO + 1) $display("FAIL tmo_stall: got %0d want %0d", sc, TMO + 1); else passed++;
    total++; if (ee !== 1'b1 || ea !== 1'b0) $display("FAIL tmo_err_pulse: got %b/%b want 1/0", ee, ea); else passed++;
    total++; if (ld !== 32'h0) $display("FAIL tmo_ldata: got %h want 0", ld); else passed++;
    ldata_m = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_loads();
    test_store();
    test_stall_delay();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
